serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin subtraction; sampled on rising edge.
REQ-005 SHALL have port a  input  WIDTH  minuend; sampled with accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; sampled with accepted start.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  single-cycle completion pulse.
REQ-009 SHALL have port diff  output  WIDTH  registered result a - b (mod 2^WIDTH).
REQ-010 SHALL have port borrow  output  1  registered final borrow-out (1 when a < b, unsigned).
REQ-011 SHALL have port zero  output  1  registered flag, 1 when the diff output equals 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 Start SHALL be accepted only when busy=0 (IDLE or DONE); start in RUN SHALL be ignored, with no effect on operands or count.
REQ-014 On accepted start: latch a and b into shift registers, clear internal borrow and bit counter, enter RUN.
REQ-015 In RUN, each edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin); d shifts into the result shift register MSB; operands shift right.
REQ-016 RUN SHALL last exactly WIDTH edges; counter width SHALL be clog2(WIDTH+1).
REQ-017 After the WIDTH-th RUN edge: enter DONE; diff, borrow and zero update simultaneously; done=1 for exactly one cycle.
REQ-018 Latency: start sampled at edge E0 -> busy=1 from E0 to E(WIDTH) -> done=1 between E(WIDTH) and E(WIDTH+1).
REQ-019 From DONE without start: return to IDLE, done=0. With start in DONE: accept per REQ-014, go directly to RUN, done=0 next cycle (back-to-back operation).
REQ-020 diff, borrow and zero SHALL hold their last completed values until the next completion; they SHALL NOT change during RUN.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.

Reset
REQ-022 rst_n=0 SHALL immediately force the FSM to IDLE and drive busy=0, done=0, diff=0, borrow=0, zero=0, counter=0, internal borrow=0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and results SHALL read 0.
REQ-024 After deassertion, the first start SHALL be accepted on the first rising edge on which it is sampled high.

Configuration
REQ-025 Macro SERIAL_SUBTRACTOR_SAT_EN SHALL select saturating output.
REQ-026 With SERIAL_SUBTRACTOR_SAT_EN defined: when final borrow=1, diff SHALL be loaded with 0 and zero with 1; borrow still reports 1.
REQ-027 Without the macro, diff SHALL be the modular result, and zero SHALL reflect that result.

Verification (WIDTH=8)
REQ-028 a=0x35, b=0x12, start pulse -> done pulse at E8 with diff=0x23, borrow=0, zero=0; busy high for exactly 8 cycles.
REQ-029 a=0x12, b=0x35 -> diff=0xDD, borrow=1, zero=0; with SERIAL_SUBTRACTOR_SAT_EN -> diff=0x00, borrow=1, zero=1.
REQ-030 a=0x7F, b=0x7F -> diff=0x00, borrow=0, zero=1; then a=0xFF, b=0x01 with start during DONE -> back-to-back, diff=0xFE, no idle cycle.
REQ-031 Start a=0x10, b=0x01; at RUN cycle 3 pulse start with a=0x00, b=0xFF -> second request ignored, result diff=0x0F, borrow=0.
REQ-032 Start a=0x80, b=0x01; assert rst_n=0 at RUN cycle 4 -> outputs 0 immediately, no done; after release, a=0x05, b=0x03 -> diff=0x02.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, WIDTH clocks per operation.
// Optional macro SERIAL_SUBTRACTOR_SAT_EN clamps negative results to zero.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb;
   logic [WIDTH-2:0] sr;
   logic [CW-1:0]    cnt;
   logic             bin;
   logic             accept, last;
   logic             d, bout;
   logic [WIDTH-1:0] res;

   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

   // Full-subtractor slice on the current LSBs.
   assign d    = sa[0] ^ sb[0] ^ bin;
   assign bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
   assign res  = {d, sr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (last)   state_nx = DONE;
         DONE:    state_nx = accept ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         cnt    <= '0;
         bin    <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
      end else if (accept) begin
         sa  <= a;
         sb  <= b;
         cnt <= '0;
         bin <= 1'b0;
      end else if (state == RUN) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         sr  <= res[WIDTH-1:1];
         bin <= bout;
         cnt <= cnt + 1'b1;
         if (last) begin
            borrow <= bout;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
            diff <= bout ? '0 : res;
            zero <= bout ? 1'b1 : (res == '0);
`else
            diff <= res;
            zero <= (res == '0);
`endif
         end
      end
   end

endmodule
